// File: rtl/game_ctl.sv
// game_ctl: breakout-style game sequencer. Turns mouse clicks, ball height
// and the live-block mask into the game state, lives, score and a board
// reload pulse for the board stage.
`timescale 1ns/1ps
module game_ctl #(
   parameter int LIVES_INIT = 3,
   parameter int FLOOR_Y    = 760,
   parameter int LOST_DELAY = 65_000_000
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        mouse_left,
   input  logic [11:0] ball_y,
   input  logic [15:0] blocks,
   output logic [2:0]  state,
   output logic        ball_hold,
   output logic [1:0]  lives,
   output logic [7:0]  score,
   output logic        board_reload
);

   typedef enum logic [2:0] {
      S_SERVE = 3'd0,
      S_PLAY  = 3'd1,
      S_LOST  = 3'd2,
      S_OVER  = 3'd3,
      S_WIN   = 3'd4
   } state_t;

   localparam logic [1:0]  LIVES_RST  = 2'(LIVES_INIT);
   localparam logic [11:0] FLOOR      = 12'(FLOOR_Y);
   localparam logic [26:0] DELAY_LAST = 27'(LOST_DELAY - 1);

   state_t      state_reg, state_next;
   logic [1:0]  lives_reg, lives_next;
   logic [7:0]  score_reg, score_next;
   logic        board_reload_reg, board_reload_next;
   logic [26:0] delay_cnt_reg, delay_cnt_next;
   logic [2:0]  sync_reg;       // [0] sync1, [1] sync2, [2] delay flop
   logic [15:0] blocks_q;
   logic        click;
   logic [15:0] cleared_mask;
   logic [4:0]  cleared_cnt;
   logic [8:0]  score_sum;
   logic [7:0]  score_sat;

   // Synchronise the raw button and keep a delayed copy for edge detection.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         sync_reg <= 3'b000;
      end else begin
         sync_reg <= {sync_reg[1:0], mouse_left};
      end
   end

   // One pulse per press: the synchronised level rose on the last edge.
   assign click = sync_reg[1] & ~sync_reg[2];

   // Remember last cycle's block mask so vanished blocks can be counted.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         blocks_q <= 16'hFFFF;
      end else begin
         blocks_q <= blocks;
      end
   end

   assign cleared_mask = blocks_q & ~blocks;

   // Popcount of blocks that disappeared this cycle.
   always_comb begin
      cleared_cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cleared_cnt = cleared_cnt + {4'd0, cleared_mask[i]};
      end
   end

   // Saturating add so the score sticks at 255 instead of wrapping.
   assign score_sum = {1'b0, score_reg} + {4'd0, cleared_cnt};
   assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

   // State, lives, score, countdown and reload pulse registers.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_reg        <= S_SERVE;
         lives_reg        <= LIVES_RST;
         score_reg        <= 8'd0;
         board_reload_reg <= 1'b0;
         delay_cnt_reg    <= 27'd0;
      end else begin
         state_reg        <= state_next;
         lives_reg        <= lives_next;
         score_reg        <= score_next;
         board_reload_reg <= board_reload_next;
         delay_cnt_reg    <= delay_cnt_next;
      end
   end

   // Next-state logic; scoring runs in every state, a restart clears it.
   always_comb begin
      state_next        = state_reg;
      lives_next        = lives_reg;
      score_next        = score_sat;
      board_reload_next = 1'b0;
      delay_cnt_next    = delay_cnt_reg;
      case (state_reg)
         S_SERVE: begin
            if (click) begin
               state_next = S_PLAY;
            end
         end
         S_PLAY: begin
            // An empty board wins even if the ball hits the floor this cycle.
            if (blocks == 16'h0000) begin
               state_next = S_WIN;
            end else if (ball_y >= FLOOR) begin
               if (lives_reg > 2'd1) begin
                  state_next     = S_LOST;
                  lives_next     = lives_reg - 2'd1;
                  delay_cnt_next = 27'd0;
               end else begin
                  state_next = S_OVER;
                  lives_next = 2'd0;
               end
            end
         end
         S_LOST: begin
            delay_cnt_next = delay_cnt_reg + 27'd1;
            if (delay_cnt_reg == DELAY_LAST) begin
               state_next = S_SERVE;
            end
         end
         S_OVER, S_WIN: begin
            if (click) begin
               state_next        = S_SERVE;
               lives_next        = LIVES_RST;
               score_next        = 8'd0;
               board_reload_next = 1'b1;
            end
         end
         default: begin
            state_next = S_SERVE;
         end
      endcase
   end

   assign state        = state_reg;
   assign ball_hold    = (state_reg != S_PLAY);
   assign lives        = lives_reg;
   assign score        = score_reg;
   assign board_reload = board_reload_reg;

endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: table vectors, directed corner sequences and a randomized run,
// all compared against a rule-level model of the game.
`timescale 1ns/1ps
module tb_game_ctl;

   localparam int LOST_DELAY = 16;
   localparam int FLOOR_Y    = 760;
   localparam int LIVES_INIT = 3;

   localparam int ST_SERVE = 0;
   localparam int ST_PLAY  = 1;
   localparam int ST_LOST  = 2;
   localparam int ST_OVER  = 3;
   localparam int ST_WIN   = 4;

   logic        pclk = 1'b0;
   logic        reset = 1'b0;
   logic        mouse_left = 1'b0;
   logic [11:0] ball_y = 12'd100;
   logic [15:0] blocks = 16'hFFFF;
   logic [2:0]  state;
   logic        ball_hold;
   logic [1:0]  lives;
   logic [7:0]  score;
   logic        board_reload;

   int checks = 0;
   int failures = 0;

   // Model: game state in plain integers; clicks are scheduled two edges
   // after the edge on which a rising button level is first seen.
   int          m_state;
   int          m_lives;
   int          m_score;
   int          m_reload;
   int          m_lost_left;
   int          m_edge;
   logic [15:0] m_prev_blocks;
   bit          m_last_ml;
   int          m_due[$];

   typedef struct {
      bit          ml;
      int          by;
      logic [15:0] bl;
      int          st;
      int          hold;
      int          lv;
      int          sc;
      int          rl;
   } vec_t;

   vec_t tbl[12];

   game_ctl #(
      .LIVES_INIT(LIVES_INIT),
      .FLOOR_Y(FLOOR_Y),
      .LOST_DELAY(LOST_DELAY)
   ) dut (
      .pclk(pclk),
      .reset(reset),
      .mouse_left(mouse_left),
      .ball_y(ball_y),
      .blocks(blocks),
      .state(state),
      .ball_hold(ball_hold),
      .lives(lives),
      .score(score),
      .board_reload(board_reload)
   );

   always #5 pclk = ~pclk;

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state       = ST_SERVE;
      m_lives       = LIVES_INIT;
      m_score       = 0;
      m_reload      = 0;
      m_lost_left   = 0;
      m_edge        = 0;
      m_prev_blocks = 16'hFFFF;
      m_last_ml     = 1'b0;
      m_due.delete();
   endfunction

   function automatic void model_step(input bit ml, input int by, input logic [15:0] bl);
      bit click;
      int sum;
      m_edge++;
      click = 1'b0;
      if (m_due.size() > 0 && m_due[0] == m_edge) begin
         click = 1'b1;
         void'(m_due.pop_front());
      end
      if (ml && !m_last_ml) m_due.push_back(m_edge + 2);
      m_last_ml = ml;

      sum = m_score + $countones(m_prev_blocks & ~bl);
      if (sum > 255) sum = 255;
      m_score       = sum;
      m_prev_blocks = bl;
      m_reload      = 0;

      case (m_state)
         ST_SERVE: if (click) m_state = ST_PLAY;
         ST_PLAY: begin
            if (bl == 16'h0000) m_state = ST_WIN;
            else if (by >= FLOOR_Y) begin
               if (m_lives > 1) begin
                  m_state     = ST_LOST;
                  m_lives     = m_lives - 1;
                  m_lost_left = LOST_DELAY;
               end else begin
                  m_state = ST_OVER;
                  m_lives = 0;
               end
            end
         end
         ST_LOST: begin
            m_lost_left--;
            if (m_lost_left == 0) m_state = ST_SERVE;
         end
         default: begin
            if (click) begin
               m_state  = ST_SERVE;
               m_lives  = LIVES_INIT;
               m_score  = 0;
               m_reload = 1;
            end
         end
      endcase
   endfunction

   task automatic compare_model();
      check("state", int'(state), m_state);
      check("ball_hold", int'(ball_hold), (m_state != ST_PLAY) ? 1 : 0);
      check("lives", int'(lives), m_lives);
      check("score", int'(score), m_score);
      check("board_reload", int'(board_reload), m_reload);
   endtask

   // One clock: drive inputs, advance DUT and model together, compare.
   task automatic step(input bit ml, input int by, input logic [15:0] bl);
      mouse_left = ml;
      ball_y     = 12'(by);
      blocks     = bl;
      @(posedge pclk);
      model_step(ml, by, bl);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      mouse_left = 1'b0;
      ball_y     = 12'd100;
      blocks     = 16'hFFFF;
      repeat (3) @(posedge pclk);
      #1;
      model_reset();
      compare_model();
      reset = 1'b1;
   endtask

   task automatic click_to_play(input int by, input logic [15:0] bl);
      step(1'b1, by, bl);
      step(1'b1, by, bl);
      step(1'b1, by, bl);
      step(1'b0, by, bl);
   endtask

   task automatic wait_state(input int want, input int max_cycles, input logic [15:0] bl);
      int n;
      n = 0;
      while (int'(state) != want && n < max_cycles) begin
         step(1'b0, 100, bl);
         n++;
      end
      check("wait_state", int'(state), want);
   endtask

   initial begin
      int lost_n;
      int rl_n;
      bit ml;
      int by;
      int r;
      logic [15:0] bl;

      tbl[0]  = '{1'b1, 100, 16'hFFFF, ST_SERVE, 1, 3, 0,  0};
      tbl[1]  = '{1'b1, 100, 16'hFFFF, ST_SERVE, 1, 3, 0,  0};
      tbl[2]  = '{1'b1, 100, 16'hFFFF, ST_PLAY,  0, 3, 0,  0};
      tbl[3]  = '{1'b1, 100, 16'hFFFF, ST_PLAY,  0, 3, 0,  0};
      tbl[4]  = '{1'b0, 759, 16'hFFFF, ST_PLAY,  0, 3, 0,  0};
      tbl[5]  = '{1'b0, 100, 16'hFFF0, ST_PLAY,  0, 3, 4,  0};
      tbl[6]  = '{1'b0, 800, 16'h0000, ST_WIN,   1, 3, 16, 0};
      tbl[7]  = '{1'b0, 800, 16'h0000, ST_WIN,   1, 3, 16, 0};
      tbl[8]  = '{1'b1, 800, 16'h0000, ST_WIN,   1, 3, 16, 0};
      tbl[9]  = '{1'b1, 800, 16'h0000, ST_WIN,   1, 3, 16, 0};
      tbl[10] = '{1'b1, 800, 16'h0000, ST_SERVE, 1, 3, 0,  1};
      tbl[11] = '{1'b0, 100, 16'hFFFF, ST_SERVE, 1, 3, 0,  0};

      // Table: serve click latency, scoring, WIN priority, restart.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].ml, tbl[i].by, tbl[i].bl);
         check("tbl_state", int'(state), tbl[i].st);
         check("tbl_hold", int'(ball_hold), tbl[i].hold);
         check("tbl_lives", int'(lives), tbl[i].lv);
         check("tbl_score", int'(score), tbl[i].sc);
         check("tbl_reload", int'(board_reload), tbl[i].rl);
         $display("vec %0d: ml=%0d y=%0d blocks=%h -> state=%0d lives=%0d score=%0d reload=%0d",
                  i, tbl[i].ml, tbl[i].by, tbl[i].bl, state, lives, score, board_reload);
      end

      // Ball lost: LOST lasts exactly LOST_DELAY cycles, clicks ignored.
      do_reset();
      click_to_play(100, 16'hFFFF);
      check("A_play", int'(state), ST_PLAY);
      step(1'b0, 760, 16'hFFFF);
      check("A_lost", int'(state), ST_LOST);
      check("A_lives", int'(lives), 2);
      lost_n = 1;
      for (int i = 0; i < 40; i++) begin
         step((i < 10) && ((i % 4) < 2), 100, 16'hFFFF);
         if (int'(state) == ST_LOST) lost_n++;
         else break;
      end
      check("A_lost_cycles", lost_n, LOST_DELAY);
      check("A_serve", int'(state), ST_SERVE);
      repeat (3) step(1'b0, 100, 16'hFFFF);
      check("A_no_click", int'(state), ST_SERVE);
      $display("seq lost: lost_cycles=%0d state=%0d lives=%0d", lost_n, state, lives);

      // Last life lost -> OVER, then restart with score clear precedence.
      click_to_play(100, 16'hFFFF);
      step(1'b0, 800, 16'hFFFF);
      check("B_lives1", int'(lives), 1);
      wait_state(ST_SERVE, 40, 16'hFFFF);
      click_to_play(100, 16'hFFFF);
      step(1'b0, 800, 16'hFFFF);
      check("B_over", int'(state), ST_OVER);
      check("B_lives0", int'(lives), 0);
      step(1'b0, 800, 16'hFF00);
      check("B_score8", int'(score), 8);
      step(1'b1, 800, 16'hFF00);
      step(1'b1, 800, 16'hFF00);
      check("B_still_over", int'(state), ST_OVER);
      step(1'b1, 800, 16'hF000);
      check("B_restart", int'(state), ST_SERVE);
      check("B_lives3", int'(lives), 3);
      check("B_score0", int'(score), 0);
      check("B_reload", int'(board_reload), 1);
      rl_n = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 100, 16'hFFFF);
         rl_n += int'(board_reload);
      end
      check("B_reload_once", rl_n, 0);
      $display("seq over: state=%0d lives=%0d score=%0d", state, lives, score);

      // Score saturation, driven while idle in SERVE.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 100, 16'hFFFF);
         step(1'b0, 100, 16'h0000);
      end
      check("C_240", int'(score), 240);
      step(1'b0, 100, 16'hFFFF);
      step(1'b0, 100, 16'h00FF);
      step(1'b0, 100, 16'h0003);
      check("C_254", int'(score), 254);
      step(1'b0, 100, 16'h0007);
      check("C_set_no_change", int'(score), 254);
      step(1'b0, 100, 16'h0000);
      check("C_sat", int'(score), 255);
      step(1'b0, 100, 16'hFFFF);
      step(1'b0, 100, 16'h0000);
      check("C_sat_hold", int'(score), 255);
      check("C_serve", int'(state), ST_SERVE);
      $display("seq saturate: score=%0d", score);

      // Asynchronous reset in the middle of a LOST countdown.
      do_reset();
      click_to_play(100, 16'hFFFF);
      step(1'b0, 800, 16'hFFFF);
      step(1'b0, 100, 16'hFF00);
      repeat (4) step(1'b0, 100, 16'hFF00);
      check("D_lost", int'(state), ST_LOST);
      #2;
      reset      = 1'b0;
      mouse_left = 1'b1;
      #1;
      check("D_rst_state", int'(state), ST_SERVE);
      check("D_rst_hold", int'(ball_hold), 1);
      check("D_rst_lives", int'(lives), LIVES_INIT);
      check("D_rst_score", int'(score), 0);
      check("D_rst_reload", int'(board_reload), 0);
      repeat (20) @(posedge pclk);
      #1;
      check("D_held_state", int'(state), ST_SERVE);
      model_reset();
      reset = 1'b1;
      step(1'b1, 100, 16'hFFFF);
      step(1'b1, 100, 16'hFFFF);
      check("D_no_early_click", int'(state), ST_SERVE);
      step(1'b1, 100, 16'hFFFF);
      check("D_held_click", int'(state), ST_PLAY);
      repeat (3) step(1'b1, 100, 16'hFFFF);
      $display("seq async reset: state=%0d lives=%0d", state, lives);

      // Randomized play against the model.
      do_reset();
      ml = 1'b0;
      bl = 16'hFFFF;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) ml = !ml;
         r = int'($urandom_range(0, 99));
         if (r < 3) by = 760 + int'($urandom_range(0, 300));
         else if (r < 6) by = 759;
         else by = int'($urandom_range(0, 700));
         r = int'($urandom_range(0, 99));
         if (r < 2) bl = 16'h0000;
         else if (r < 8) bl = 16'hFFFF;
         else if (r < 20) bl = bl & ~(16'(1) << $urandom_range(0, 15));
         else if (r < 23) bl = bl & 16'($urandom);
         step(ml, by, bl);
      end
      $display("random run: 3000 cycles, final state=%0d lives=%0d score=%0d", state, lives, score);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
